// File: rtl/frame_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_ctrl_pkg
//  Description : Shared encodings for the frame buffer scheduler: bank status,
//                writer/reader FSM states and memory enable polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_buf_ctrl_pkg;

  // Per-bank ownership status
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  // Writer FSM
  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_e;

  // Reader FSM
  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_e;

  // data_mem enables are active-low
  localparam logic c_EN_ASSERT   = 1'b0;
  localparam logic c_EN_DEASSERT = 1'b1;

  // Advance a bank index around the ring of LIMIT banks
  function automatic int wrap_inc(input int idx, input int limit);
    return (idx + 1 >= limit) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_ctrl_if
//  Description : Pixel writer / reader handshakes and data_mem bank controls.
//                slave = scheduler side, master = pixel client / memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_buf_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int BUF_W      = 1,
  parameter int CNT_W      = 8
) ();

  logic                  wr_valid;
  logic                  wr_ready;
  logic                  rd_req;
  logic                  rd_ready;
  logic                  rd_valid;
  logic                  rd_frame_start;
  logic                  rd_frame_end;
  logic                  mem_wr_en;
  logic [BUF_W-1:0]      mem_wr_buf;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic                  mem_rd_en;
  logic [BUF_W-1:0]      mem_rd_buf;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [BUF_W:0]        frames_full;
  logic [CNT_W-1:0]      overflow_cnt;

  modport slave (
    input  wr_valid, rd_req,
    output wr_ready, rd_ready, rd_valid, rd_frame_start, rd_frame_end,
           mem_wr_en, mem_wr_buf, mem_wr_addr,
           mem_rd_en, mem_rd_buf, mem_rd_addr,
           frames_full, overflow_cnt
  );

  modport master (
    output wr_valid, rd_req,
    input  wr_ready, rd_ready, rd_valid, rd_frame_start, rd_frame_end,
           mem_wr_en, mem_wr_buf, mem_wr_addr,
           mem_rd_en, mem_rd_buf, mem_rd_addr,
           frames_full, overflow_cnt
  );

endinterface
`default_nettype wire

// File: rtl/frame_buf_ctrl_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : frame_addr_seq
//  Description : Per-frame word address counter: load-zero on bank claim,
//                increment on accepted handshake, flags the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_addr_seq #(
  parameter int ADDR_WIDTH = 3
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  clear_i,
  input  wire logic                  inc_i,
  output logic      [ADDR_WIDTH-1:0] addr_o,
  output logic                       last_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Clear wins over increment; the last-word increment wraps back to zero
  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Address register
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = &addr_q;

endmodule
`default_nettype wire

// File: rtl/frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_ctrl
//  Description : N-bank ping-pong frame scheduler. Writer fills banks in ring
//                order, reader drains completed banks in the same order.
//                Bank status is registered so a hand-over between writer and
//                reader always takes at least one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_ctrl
  import frame_buf_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_BUFS   = 2,
  parameter int BUF_W      = 1,
  parameter int CNT_W      = 8
) (
  input wire logic         clk,
  input wire logic         reset,
  frame_buf_ctrl_if.slave  bus
);

  bank_state_e           bank_q [NUM_BUFS];
  wr_state_e             w_state_q;
  rd_state_e             r_state_q;
  logic [BUF_W-1:0]      w_buf_q;
  logic [BUF_W-1:0]      r_buf_q;
  logic                  rd_valid_q;
  logic                  rd_start_q;
  logic                  rd_end_q;
  logic [CNT_W-1:0]      ovf_q;
  logic [CNT_W-1:0]      ovf_d;
  logic [BUF_W:0]        full_cnt;

  logic                  w_wr_ready;
  logic                  w_rd_ready;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_claim;
  logic                  w_rd_claim;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic                  w_wr_last;
  logic                  w_rd_last;

  assign w_wr_ready = (w_state_q == W_FILL);
  assign w_rd_ready = (r_state_q == R_READ);
  assign w_wr_acc   = bus.wr_valid & w_wr_ready;
  assign w_rd_acc   = bus.rd_req & w_rd_ready;
  assign w_wr_claim = (w_state_q == W_IDLE) && (bank_q[w_buf_q] == BANK_EMPTY);
  assign w_rd_claim = (r_state_q == R_IDLE) && (bank_q[r_buf_q] == BANK_FULL);

  frame_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (w_wr_claim),
    .inc_i   (w_wr_acc),
    .addr_o  (w_wr_addr),
    .last_o  (w_wr_last)
  );

  frame_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .clk     (clk),
    .reset   (reset),
    .clear_i (w_rd_claim),
    .inc_i   (w_rd_acc),
    .addr_o  (w_rd_addr),
    .last_o  (w_rd_last)
  );

  // Writer and reader FSMs share the bank status table; they only ever
  // touch banks in different states, so their updates never collide
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFS; i++) begin
        bank_q[i] <= BANK_EMPTY;
      end
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      w_buf_q    <= '0;
      r_buf_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_start_q <= 1'b0;
      rd_end_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (w_wr_claim) begin
            bank_q[w_buf_q] <= BANK_FILLING;
            w_state_q       <= W_FILL;
          end
        end
        W_FILL: begin
          if (w_wr_acc && w_wr_last) begin
            bank_q[w_buf_q] <= BANK_FULL;
            w_buf_q         <= BUF_W'(wrap_inc(int'(w_buf_q), NUM_BUFS));
            w_state_q       <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase

      case (r_state_q)
        R_IDLE: begin
          if (w_rd_claim) begin
            bank_q[r_buf_q] <= BANK_READING;
            r_state_q       <= R_READ;
          end
        end
        R_READ: begin
          if (w_rd_acc && w_rd_last) begin
            bank_q[r_buf_q] <= BANK_EMPTY;
            r_buf_q         <= BUF_W'(wrap_inc(int'(r_buf_q), NUM_BUFS));
            r_state_q       <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase

      // Read data appears one cycle after the accepted request
      rd_valid_q <= w_rd_acc;
      rd_start_q <= w_rd_acc && (w_rd_addr == '0);
      rd_end_q   <= w_rd_acc && w_rd_last;
    end
  end

  // Saturating count of writer words offered while no bank is open
  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_valid && !w_wr_ready && !(&ovf_q)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  // Overflow counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  // Number of completed frames waiting for the reader
  always_comb begin
    full_cnt = '0;
    for (int i = 0; i < NUM_BUFS; i++) begin
      if (bank_q[i] == BANK_FULL) begin
        full_cnt = full_cnt + 1'b1;
      end
    end
  end

  assign bus.wr_ready       = w_wr_ready;
  assign bus.rd_ready       = w_rd_ready;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_frame_start = rd_start_q;
  assign bus.rd_frame_end   = rd_end_q;
  assign bus.mem_wr_en      = w_wr_acc ? c_EN_ASSERT : c_EN_DEASSERT;
  assign bus.mem_wr_buf     = w_buf_q;
  assign bus.mem_wr_addr    = w_wr_addr;
  assign bus.mem_rd_en      = w_rd_acc ? c_EN_ASSERT : c_EN_DEASSERT;
  assign bus.mem_rd_buf     = r_buf_q;
  assign bus.mem_rd_addr    = w_rd_addr;
  assign bus.frames_full    = full_cnt;
  assign bus.overflow_cnt   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buf_ctrl
//  Description : Self-checking bench for frame_buf_ctrl: vector table, directed
//                multi-cycle sequences and random traffic against a queue-based
//                reference model of frame ownership.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_ctrl;

  localparam int AW   = 3;
  localparam int NB   = 2;
  localparam int BW   = 1;
  localparam int CW   = 8;
  localparam int LEN  = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.ADDR_WIDTH(AW), .BUF_W(BW), .CNT_W(CW)) bus ();

  frame_buf_ctrl #(.ADDR_WIDTH(AW), .NUM_BUFS(NB), .BUF_W(BW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: writer/reader progress plus an ordered queue of
  // completed frames (bank indices) awaiting the reader
  bit m_wfill = 0, m_rread = 0, m_rv = 0, m_rs = 0, m_re = 0;
  int m_wbuf = 0, m_waddr = 0, m_rbuf = 0, m_raddr = 0, m_ovf = 0;
  int m_fullq[$];
  logic cur_r, cur_wv, cur_rq;

  function automatic bit bank_free(input int b);
    foreach (m_fullq[i]) if (m_fullq[i] == b) return 0;
    if (m_rread && m_rbuf == b) return 0;
    return 1;
  endfunction

  task automatic check_model();
    bit wacc, racc;
    wacc = cur_wv && m_wfill;
    racc = cur_rq && m_rread;
    checks++;
    if (bus.wr_ready !== m_wfill || bus.rd_ready !== m_rread ||
        bus.mem_wr_en !== !wacc || bus.mem_rd_en !== !racc ||
        bus.mem_wr_addr !== AW'(m_waddr) || bus.mem_rd_addr !== AW'(m_raddr) ||
        bus.mem_wr_buf !== BW'(m_wbuf) || bus.mem_rd_buf !== BW'(m_rbuf) ||
        bus.rd_valid !== m_rv || bus.rd_frame_start !== m_rs || bus.rd_frame_end !== m_re ||
        bus.frames_full !== (BW+1)'(m_fullq.size()) || bus.overflow_cnt !== CW'(m_ovf)) begin
      errors++;
      $display("FAIL model @%0t got rdy=%b%b en=%b%b wa=%0d ra=%0d wb=%0d rb=%0d v/s/e=%b%b%b ff=%0d ovf=%0d exp rdy=%b%b en=%b%b wa=%0d ra=%0d wb=%0d rb=%0d v/s/e=%b%b%b ff=%0d ovf=%0d",
               $time, bus.wr_ready, bus.rd_ready, bus.mem_wr_en, bus.mem_rd_en, bus.mem_wr_addr,
               bus.mem_rd_addr, bus.mem_wr_buf, bus.mem_rd_buf, bus.rd_valid, bus.rd_frame_start,
               bus.rd_frame_end, bus.frames_full, bus.overflow_cnt,
               m_wfill, m_rread, !wacc, !racc, m_waddr, m_raddr, m_wbuf, m_rbuf, m_rv, m_rs, m_re,
               m_fullq.size(), m_ovf);
    end
  endtask

  task automatic advance();
    bit wacc, racc, wfree, rhave;
    if (cur_r) begin
      m_wfill = 0; m_rread = 0; m_rv = 0; m_rs = 0; m_re = 0;
      m_wbuf = 0; m_waddr = 0; m_rbuf = 0; m_raddr = 0; m_ovf = 0;
      m_fullq.delete();
      return;
    end
    wacc  = cur_wv && m_wfill;
    racc  = cur_rq && m_rread;
    wfree = bank_free(m_wbuf);
    rhave = (m_fullq.size() > 0);
    m_rv = racc;
    m_rs = racc && (m_raddr == 0);
    m_re = racc && (m_raddr == LEN - 1);
    if (cur_wv && !m_wfill && m_ovf < CMAX) m_ovf++;
    // reader first, so a frame completed this edge is only visible next cycle
    if (m_rread) begin
      if (racc) begin
        if (m_raddr == LEN - 1) begin
          m_rread = 0; m_raddr = 0; m_rbuf = (m_rbuf + 1) % NB;
        end else m_raddr++;
      end
    end else if (rhave) begin
      m_rread = 1; m_raddr = 0; m_rbuf = m_fullq.pop_front();
    end
    if (m_wfill) begin
      if (wacc) begin
        if (m_waddr == LEN - 1) begin
          m_fullq.push_back(m_wbuf);
          m_wfill = 0; m_waddr = 0; m_wbuf = (m_wbuf + 1) % NB;
        end else m_waddr++;
      end
    end else if (wfree) begin
      m_wfill = 1; m_waddr = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic wv, input logic rq);
    cur_r = r; cur_wv = wv; cur_rq = rq;
    reset = r; bus.wr_valid = wv; bus.rd_req = rq;
    @(negedge clk);
    check_model();
  endtask

  task automatic fin();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic r, input logic wv, input logic rq);
    cyc(r, wv, rq);
    fin();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  typedef struct {
    logic r, wv, rq;
    logic e_rdy, e_en;
    int   e_addr, e_buf, e_ff, e_ovf;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int wp, rp;
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;

    // Reset then first frame on bank 0, one idle cycle, bank 1 opens
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) tbl[3 + i] = '{0, 1, 0, 1, 0, i, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 1, 0, 1, 1, 1};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 1, 0, 2};

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].r, tbl[i].wv, tbl[i].rq);
      checks++;
      if (bus.wr_ready !== tbl[i].e_rdy || bus.mem_wr_en !== tbl[i].e_en ||
          bus.mem_wr_addr !== AW'(tbl[i].e_addr) || bus.mem_wr_buf !== BW'(tbl[i].e_buf) ||
          bus.frames_full !== (BW+1)'(tbl[i].e_ff) || bus.overflow_cnt !== CW'(tbl[i].e_ovf)) begin
        errors++;
        $display("FAIL vec[%0d] got rdy=%b en=%b addr=%0d buf=%0d ff=%0d ovf=%0d exp rdy=%b en=%b addr=%0d buf=%0d ff=%0d ovf=%0d",
                 i, bus.wr_ready, bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_buf, bus.frames_full,
                 bus.overflow_cnt, tbl[i].e_rdy, tbl[i].e_en, tbl[i].e_addr, tbl[i].e_buf,
                 tbl[i].e_ff, tbl[i].e_ovf);
      end
      fin();
    end

    // Two frames with no reads, writer keeps offering for 5 more cycles
    run(1, 0, 0); run(1, 0, 0);
    run(0, 0, 0);
    for (int i = 0; i < 22; i++) run(0, 1, 0);
    cyc(0, 0, 0);
    chk("ovf_after_stall", bus.overflow_cnt, 6);
    chk("stall_wr_ready", bus.wr_ready, 0);
    chk("stall_frames_full", bus.frames_full, 1);
    fin();

    // Drain bank 0 with rd_req held high
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("rd_en", bus.mem_rd_en, 0);
      chk("rd_buf", bus.mem_rd_buf, 0);
      chk("rd_addr", bus.mem_rd_addr, i);
      if (i > 0) begin
        chk("rd_valid", bus.rd_valid, 1);
        chk("rd_start", bus.rd_frame_start, (i == 1) ? 1 : 0);
        chk("rd_end_early", bus.rd_frame_end, 0);
      end
      fin();
    end
    cyc(0, 0, 0);
    chk("rd_end", bus.rd_frame_end, 1);
    chk("rd_valid_last", bus.rd_valid, 1);
    chk("wr_no_same_cycle_claim", bus.wr_ready, 0);
    fin();
    cyc(0, 0, 0);
    chk("wr_reclaim_ready", bus.wr_ready, 1);
    chk("wr_reclaim_buf", bus.mem_wr_buf, 0);
    chk("rd_next_buf", bus.mem_rd_buf, 1);
    chk("rd_next_ready", bus.rd_ready, 1);
    fin();

    // Alternating wr_valid: frame completes after 16 cycles
    run(1, 0, 0); run(1, 0, 0);
    run(0, 0, 0);
    for (int c = 0; c < 16; c++) begin
      cyc(0, logic'(c % 2), 0);
      chk("alt_addr", bus.mem_wr_addr, c / 2);
      chk("alt_en", bus.mem_wr_en, (c % 2 == 1) ? 0 : 1);
      chk("alt_ready", bus.wr_ready, 1);
      fin();
    end
    cyc(0, 0, 0);
    chk("alt_full", bus.frames_full, 1);
    chk("alt_gap", bus.wr_ready, 0);
    chk("alt_next_buf", bus.mem_wr_buf, 1);
    fin();

    // Reset while reading bank 0 with bank 1 FULL
    run(1, 0, 0); run(1, 0, 0);
    run(0, 0, 0);
    for (int i = 0; i < 17; i++) run(0, 1, 0);
    for (int i = 0; i < 3; i++) run(0, 0, 1);
    cyc(0, 0, 0);
    chk("pre_rst_full", bus.frames_full, 1);
    chk("pre_rst_raddr", bus.mem_rd_addr, 3);
    fin();
    run(1, 1, 1);
    cyc(1, 0, 0);
    chk("rst_full", bus.frames_full, 0);
    chk("rst_wbuf", bus.mem_wr_buf, 0);
    chk("rst_rbuf", bus.mem_rd_buf, 0);
    chk("rst_raddr", bus.mem_rd_addr, 0);
    chk("rst_rdy", {bus.wr_ready, bus.rd_ready, bus.rd_valid}, 0);
    chk("rst_en", {bus.mem_wr_en, bus.mem_rd_en}, 3);
    chk("rst_ovf", bus.overflow_cnt, 0);
    fin();
    run(0, 1, 0);
    cyc(0, 1, 0);
    chk("post_rst_buf", bus.mem_wr_buf, 0);
    chk("post_rst_addr", bus.mem_wr_addr, 0);
    chk("post_rst_en", bus.mem_wr_en, 0);
    fin();

    // Overflow counter saturation
    run(1, 0, 0);
    for (int i = 0; i < 300; i++) run(0, 1, 0);
    cyc(0, 0, 0);
    chk("ovf_saturate", bus.overflow_cnt, CMAX);
    fin();

    // Random traffic with occasional resets
    run(1, 0, 0);
    for (int seg = 0; seg < 6; seg++) begin
      wp = $urandom_range(20, 100);
      rp = $urandom_range(20, 100);
      for (int i = 0; i < 500; i++) begin
        run(logic'($urandom_range(0, 399) == 0),
            logic'($urandom_range(0, 99) < wp),
            logic'($urandom_range(0, 99) < rp));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
